fetch_align: RTL
================

Name: fetch_align

Overview:
- Sits between instruction fetch and the compressed/full decode stage.
- Accepts 32-bit fetch words, queues them as halfwords, and presents one RISC-V instruction per handshake with its PC.
- Each instruction is either 16-bit RVC (lower 16 bits valid, upper zero) or 32-bit; a 32-bit instruction may straddle two fetch words.
- Discards stale fetch responses after a redirect (flush).

Parameters:
- DEPTH, 8, queue capacity in halfwords; even, at least 4.
- RESET_PC, 32'h0, expected fetch address after reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  redirect; empty the queue and restart at flush_pc
- flush_pc  in  32  new PC; bit 0 ignored, bit 1 may be set
- fetch_valid  in  1  fetch word present
- fetch_addr  in  32  word address of fetch_data; bits [1:0] ignored
- fetch_data  in  32  fetched word, little-endian halfwords
- fetch_ready  out  1  block can accept a word this cycle
- align_valid  out  1  instruction available
- align_ready  in  1  downstream consumes the instruction
- align_instr  out  32  instruction; RVC zero-extended from 16 bits
- align_pc  out  32  PC of align_instr
- align_rvc  out  1  1 = 16-bit instruction

Behaviour:
- One clock, rising edge. Reset is synchronous and active-high.
- Internal state:
  - halfword circular queue: DEPTH entries, head/tail pointers, count 0..DEPTH
  - head_pc: PC of the queue head
  - exp_pc: next expected halfword fetch address
- Reset values:
  - count=0, pointers=0, head_pc=RESET_PC, exp_pc=RESET_PC.
  - Outputs: fetch_ready=1, align_valid=0, align_instr=0, align_pc=RESET_PC, align_rvc=0.
- fetch_ready = (DEPTH-count >= 2) && !flush.
  - Computed from registered count only; a same-cycle pop is not credited.
- Word accept condition: fetch_valid && fetch_ready && fetch_addr[31:2]==exp_pc[31:2].
  - fetch_valid && fetch_ready with an address mismatch: word silently dropped, no state change.
- On accept:
  - exp_pc[1]==0: push fetch_data[15:0] then [31:16] (2 entries).
  - exp_pc[1]==1: push only [31:16] (1 entry). Occurs only on the first word after a misaligned flush.
  - exp_pc <= {exp_pc[31:2]+1, 2'b00}.
- Output decode is combinational from registered queue state (no added latency). A word accepted in cycle N is visible at align_* in cycle N+1.
  - Head halfword [1:0] != 2'b11: align_rvc=1, align_valid=(count>=1), align_instr={16'b0,head}.
  - Otherwise: align_rvc=0, align_valid=(count>=2), align_instr={head+1,head}.
  - Head is 32-bit and count==1: align_valid=0; wait for the next word. This is the straddle case.
  - align_pc=head_pc.
  - When align_valid=0, align_instr and align_rvc still reflect the head entry and have no meaning.
- Pop on align_valid && align_ready && !flush:
  - Remove 1 entry (rvc) or 2 entries.
  - head_pc += 2 or 4.
- Push and pop in the same cycle are allowed: count_next = count + pushed - popped. Pointers wrap modulo DEPTH.
- Flush has priority over accept and pop in the same cycle.
  - Queue emptied (count=0, head=tail).
  - head_pc <= {flush_pc[31:1],1'b0}; exp_pc <= same value.
  - align_valid is 0 in the following cycle.
- Reset asserted mid-operation overrides flush and all traffic. The next cycle matches the reset values.

Optional Feature:
- Macro: FETCH_FAULT_EN.
- Defined:
  - Adds input fetch_fault (1) and output align_fault (1).
  - Each queue entry carries a fault bit, copied from fetch_fault on push.
  - align_fault = OR of the fault bits of the entries forming the instruction.
  - A faulting head entry is presented as a complete instruction regardless of its [1:0] bits: align_rvc=1, align_valid=(count>=1). This prevents deadlock when no further word will arrive.
- Undefined: no ports, no fault storage; behaviour as above.

Decomposition:
- Wires package: fetch_align_in_type / fetch_align_out_type structs.
- Constants package:
  - halfword_type (16 bits)
  - rvc_full_opcode constant 2'b11
- One natural sub-module: align_queue.
  - Parameterized halfword circular buffer with push of 1 or 2 entries and pop of 1 or 2 entries per cycle.
  - Exposes count, head and head+1 entries.
  - fetch_align holds the PC logic, fetch_ready/align_valid generation and flush control.

Test Plan:
- Reset, then word 0x00000000 with data 0x45014501 (two c.li) -> cycle+1: align_valid=1, rvc=1, pc=0, instr=0x00004501; next pc=2; then empty.
- Data 0x00A00513 (addi) at 0x0 -> align_rvc=0, instr=0x00A00513, pc=0, popped 2 entries.
- Straddle: word@0x0=0x05134501, word@0x4=0x000000A0 -> c.li at pc 0; align_valid=0 until word@0x4 arrives; then instr=0x00A00513 at pc 2.
- flush with flush_pc=0x102, then word@0x100 data 0x4505ABCD -> lower half dropped; rvc 0x4505 at pc 0x102. A stale word@0x0 presented after the flush is dropped.
- Fill with align_ready=0 -> fetch_ready=0 at count=DEPTH-1 and at DEPTH. Then same-cycle push+pop -> count stays constant and pointers wrap correctly.
- FETCH_FAULT_EN: fault word whose lower halfword has [1:0]=2'b11 -> align_valid=1, align_fault=1, align_rvc=1 without waiting for a second word.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// fetch_align_pkg: shared types and constants for the fetch aligner.
//   halfword_type       16-bit queue payload
//   rvc_full_opcode     low two bits marking a 32-bit instruction
//   fetch_align_in_type / fetch_align_out_type  bundled port payloads
// Optional feature macro: FETCH_FAULT_EN adds a per-entry fault bit.
package fetch_align_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned HW_W = 16;

  typedef logic [HW_W-1:0] halfword_type;

  localparam logic [1:0] rvc_full_opcode = 2'b11;

`ifdef FETCH_FAULT_EN
  localparam int unsigned ENTRY_W = HW_W + 1;
`else
  localparam int unsigned ENTRY_W = HW_W;
`endif

  typedef struct packed {
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] fetch_data;
`ifdef FETCH_FAULT_EN
    logic            fetch_fault;
`endif
    logic            align_ready;
  } fetch_align_in_type;

  typedef struct packed {
    logic            fetch_ready;
    logic            align_valid;
    logic [XLEN-1:0] align_instr;
    logic [XLEN-1:0] align_pc;
    logic            align_rvc;
`ifdef FETCH_FAULT_EN
    logic            align_fault;
`endif
  } fetch_align_out_type;

endpackage

// File: rtl/fetch_align_if.sv
// fetch_align_if: fetch-word input and aligned-instruction output bundle.
//   fetch_valid/fetch_addr/fetch_data/fetch_ready  fetch side handshake
//   align_valid/align_ready/align_instr/align_pc/align_rvc  decode side
//   slave modport = aligner, master modport = its environment
// Optional feature macro: FETCH_FAULT_EN adds fetch_fault / align_fault.
interface fetch_align_if;

  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        align_valid;
  logic        align_ready;
  logic [31:0] align_instr;
  logic [31:0] align_pc;
  logic        align_rvc;
`ifdef FETCH_FAULT_EN
  logic        fetch_fault;
  logic        align_fault;
`endif

`ifdef FETCH_FAULT_EN
  modport slave (
    input  fetch_valid, fetch_addr, fetch_data, fetch_fault, align_ready,
    output fetch_ready, align_valid, align_instr, align_pc, align_rvc, align_fault
  );
  modport master (
    output fetch_valid, fetch_addr, fetch_data, fetch_fault, align_ready,
    input  fetch_ready, align_valid, align_instr, align_pc, align_rvc, align_fault
  );
`else
  modport slave (
    input  fetch_valid, fetch_addr, fetch_data, align_ready,
    output fetch_ready, align_valid, align_instr, align_pc, align_rvc
  );
  modport master (
    output fetch_valid, fetch_addr, fetch_data, align_ready,
    input  fetch_ready, align_valid, align_instr, align_pc, align_rvc
  );
`endif

endinterface

// File: rtl/fetch_align_align_queue.sv
// align_queue: circular buffer of WIDTH-bit entries, push 1 or 2 and pop
// 1 or 2 per cycle. Caller guarantees room on push and data on pop.
//   clock, reset       clock, synchronous active-high reset
//   clear              empty the buffer (pointers and count to zero)
//   push_en/push_two   write push_data0 (and push_data1 when push_two)
//   pop_en/pop_two     drop one (or two) entries from the head
//   count              number of valid entries, 0..DEPTH
//   head0/head1        entry at head and the one after it
module align_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push_en,
  input  logic             push_two,
  input  logic [WIDTH-1:0] push_data0,
  input  logic [WIDTH-1:0] push_data1,
  input  logic             pop_en,
  input  logic             pop_two,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head0,
  output logic [WIDTH-1:0] head1
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       n_push, n_pop;

  // Pointer advance that wraps modulo DEPTH (DEPTH need not be a power of 2).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] inc);
    int unsigned s;
    s = 32'(p) + 32'(inc);
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    n_push  = push_en ? (push_two ? 2'd2 : 2'd1) : 2'd0;
    n_pop   = pop_en  ? (pop_two  ? 2'd2 : 2'd1) : 2'd0;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) begin
        mem_d[tail_q] = push_data0;
        if (push_two) mem_d[ptr_add(tail_q, 2'd1)] = push_data1;
        tail_d = ptr_add(tail_q, n_push);
      end
      if (pop_en) head_d = ptr_add(head_q, n_pop);
      count_d = count_q + CW'(n_push) - CW'(n_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count = count_q;
  assign head0 = mem_q[head_q];
  assign head1 = mem_q[ptr_add(head_q, 2'd1)];

endmodule

// File: rtl/fetch_align.sv
// fetch_align: splits 32-bit fetch words into halfwords and hands out one
// RISC-V instruction (16-bit RVC or 32-bit, possibly straddling two words)
// per handshake together with its PC. A flush redirects to flush_pc and
// discards queued and stale fetch data.
//   clock, reset        clock, synchronous active-high reset
//   flush, flush_pc     redirect request and new PC (bit 0 ignored)
//   bus (slave)         fetch_* input handshake, align_* output handshake
// Optional feature macro: FETCH_FAULT_EN (fetch_fault in, align_fault out).
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  fetch_align_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_align_in_type  in_s;
  fetch_align_out_type out_s;

  logic [CW-1:0]      q_count;
  logic [ENTRY_W-1:0] q_head0, q_head1;
  logic [ENTRY_W-1:0] push_data0, push_data1;
  logic               fetch_ready_c, accept, push_two;
  logic               rvc, dec_valid, pop, pop_two;
  logic [31:0]        head_pc_q, head_pc_d;
  logic [31:0]        exp_pc_q, exp_pc_d;
  logic [31:0]        flush_target;
  halfword_type       head_hw, next_hw, lo_hw, hi_hw;
  logic               unused_bits;
`ifdef FETCH_FAULT_EN
  logic               head_fault, next_fault;
`endif

  // Gather interface inputs into one payload.
  always_comb begin
    in_s             = '0;
    in_s.fetch_valid = bus.fetch_valid;
    in_s.fetch_addr  = bus.fetch_addr;
    in_s.fetch_data  = bus.fetch_data;
`ifdef FETCH_FAULT_EN
    in_s.fetch_fault = bus.fetch_fault;
`endif
    in_s.align_ready = bus.align_ready;
  end

  assign flush_target = {flush_pc[31:1], 1'b0};
  assign unused_bits  = ^{in_s.fetch_addr[1:0], flush_pc[0]};

  // Fetch acceptance: room for a full word, no redirect, expected address.
  always_comb begin
    fetch_ready_c = (q_count <= CW'(DEPTH - 2)) && !flush;
    accept        = in_s.fetch_valid && fetch_ready_c &&
                    (in_s.fetch_addr[31:2] == exp_pc_q[31:2]);
    // A misaligned restart keeps only the upper halfword of the first word.
    push_two      = !exp_pc_q[1];
    lo_hw         = in_s.fetch_data[15:0];
    hi_hw         = in_s.fetch_data[31:16];
`ifdef FETCH_FAULT_EN
    push_data0    = {in_s.fetch_fault, (push_two ? lo_hw : hi_hw)};
    push_data1    = {in_s.fetch_fault, hi_hw};
`else
    push_data0    = push_two ? lo_hw : hi_hw;
    push_data1    = hi_hw;
`endif
  end

  // Instruction length decode at the queue head.
  always_comb begin
    head_hw = q_head0[HW_W-1:0];
    next_hw = q_head1[HW_W-1:0];
    rvc     = (head_hw[1:0] != rvc_full_opcode);
`ifdef FETCH_FAULT_EN
    head_fault = q_head0[HW_W];
    next_fault = q_head1[HW_W];
    // A faulting head is emitted alone so it never waits for a second word.
    if (head_fault) rvc = 1'b1;
`endif
    dec_valid = rvc ? (q_count >= CW'(1)) : (q_count >= CW'(2));
    pop       = dec_valid && in_s.align_ready && !flush;
    pop_two   = !rvc;
  end

  // Output payload.
  always_comb begin
    out_s             = '0;
    out_s.fetch_ready = fetch_ready_c;
    out_s.align_valid = dec_valid;
    out_s.align_instr = rvc ? {16'h0000, head_hw} : {next_hw, head_hw};
    out_s.align_pc    = head_pc_q;
    // Empty queue reports a 32-bit-style idle value.
    out_s.align_rvc   = rvc && (q_count != '0);
`ifdef FETCH_FAULT_EN
    out_s.align_fault = rvc ? head_fault : (head_fault | next_fault);
`endif
  end

  // PC tracking: head PC advances on pop, expected fetch PC on accept.
  always_comb begin
    head_pc_d = head_pc_q;
    exp_pc_d  = exp_pc_q;
    if (flush) begin
      head_pc_d = flush_target;
      exp_pc_d  = flush_target;
    end else begin
      if (pop)    head_pc_d = head_pc_q + (pop_two ? 32'd4 : 32'd2);
      if (accept) exp_pc_d  = {exp_pc_q[31:2] + 30'd1, 2'b00};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_pc_q <= RESET_PC;
      exp_pc_q  <= RESET_PC;
    end else begin
      head_pc_q <= head_pc_d;
      exp_pc_q  <= exp_pc_d;
    end
  end

  align_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CW    (CW)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .clear      (flush),
    .push_en    (accept),
    .push_two   (push_two),
    .push_data0 (push_data0),
    .push_data1 (push_data1),
    .pop_en     (pop),
    .pop_two    (pop_two),
    .count      (q_count),
    .head0      (q_head0),
    .head1      (q_head1)
  );

  assign bus.fetch_ready = out_s.fetch_ready;
  assign bus.align_valid = out_s.align_valid;
  assign bus.align_instr = out_s.align_instr;
  assign bus.align_pc    = out_s.align_pc;
  assign bus.align_rvc   = out_s.align_rvc;
`ifdef FETCH_FAULT_EN
  assign bus.align_fault = out_s.align_fault;
`endif

endmodule
